// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function encodings for the Y86-64 execute stage
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  typedef enum logic [1:0] {
    FUN_ADD = ALU_ADD,
    FUN_SUB = ALU_SUB,
    FUN_AND = ALU_AND,
    FUN_XOR = ALU_XOR
  } alu_fun_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational add/sub/and/xor with signed overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fun,
  output logic [WIDTH-1:0] result,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  alu_fun_t funSel;
  assign funSel = alu_fun_t'(fun);

  // Select the operation; sub is b - a (Y86 rB - rA), carry out of the MSB is dropped.
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (funSel)
      FUN_ADD: begin
        result = a + b;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      FUN_SUB: begin
        result = b - a;
        of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      FUN_AND: result = a & b;
      FUN_XOR: result = a ^ b;
      default: begin
        result = '0;
        of     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/y86_alu_wrapper.sv
// rtl/y86_alu_wrapper.sv - registered Y86-64 ALU; ALU_FLAGS_EN adds registered zf/sf
module y86_alu_wrapper
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             of
`ifdef ALU_FLAGS_EN
  ,
  output logic             zf,
  output logic             sf
`endif
);

  logic [WIDTH-1:0] coreResult;
  logic             coreOf;

  alu_core #(
    .WIDTH (WIDTH)
  ) uCore (
    .a      (a),
    .b      (b),
    .fun    (fun),
    .result (coreResult),
    .of     (coreOf)
  );

  // Output register: capture a new result on in_valid, otherwise hold it and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      of        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= coreResult;
        of  <= coreOf;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  // Zero/sign flags derived from the same result and registered with identical timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      sf <= 1'b0;
    end else if (in_valid) begin
      zf <= (coreResult == '0);
      sf <= coreResult[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_y86_alu_wrapper.sv
// tb/tb_y86_alu_wrapper.sv - directed self-checking bench for y86_alu_wrapper
module tb_y86_alu_wrapper;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  fun;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic [63:0] out;
  logic        of;
`ifdef ALU_FLAGS_EN
  logic        zf;
  logic        sf;
`endif

  int compared;
  int mismatched;

  y86_alu_wrapper #(
    .WIDTH (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .fun       (fun),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out),
    .of        (of)
`ifdef ALU_FLAGS_EN
    ,
    .zf        (zf),
    .sf        (sf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation at the falling edge, then settle just past the next rising edge.
  task automatic drive(input logic v, input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    in_valid = v;
    fun      = f;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 2'd0, 64'd2, 64'd3);
    compared++;
    if (out_valid !== 1'b1 || out !== 64'd5) begin
      mismatched++;
      $display("FAIL pre_reset: out_valid=%0b out=%h want 1 / %h", out_valid, out, 64'd5);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out !== 64'd0 || of !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async: out=%h of=%0b out_valid=%0b want 0/0/0", out, of, out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (out !== 64'd0 || of !== 1'b0 || out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold: out=%h of=%0b out_valid=%0b want 0/0/0", out, of, out_valid);
      end
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (zf !== 1'b0 || sf !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: zf=%0b sf=%0b want 0/0", zf, sf);
    end
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL post_release_idle: out_valid=%0b want 0", out_valid);
    end
    drive(1'b1, 2'd0, 64'd4, 64'd6);
    compared++;
    if (out_valid !== 1'b1 || out !== 64'd10 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL first_after_reset: out_valid=%0b out=%h of=%0b want 1/%h/0", out_valid, out, of, 64'd10);
    end
  endtask

  task automatic test_add;
    drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100);
    compared++;
    if (out !== 64'hF8 || of !== 1'b0 || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL add_minus8: out=%h of=%0b want %h/0", out, of, 64'hF8);
    end
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    compared++;
    if (out !== 64'h8000_0000_0000_0000 || of !== 1'b1) begin
      mismatched++;
      $display("FAIL add_pos_ovf: out=%h of=%0b want %h/1", out, of, 64'h8000_0000_0000_0000);
    end
    drive(1'b1, 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    compared++;
    if (out !== 64'd0 || of !== 1'b1) begin
      mismatched++;
      $display("FAIL add_neg_ovf: out=%h of=%0b want 0/1", out, of);
    end
    drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    compared++;
    if (out !== 64'd0 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL add_wrap: out=%h of=%0b want 0/0", out, of);
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (zf !== 1'b1 || sf !== 1'b0) begin
      mismatched++;
      $display("FAIL add_wrap_flags: zf=%0b sf=%0b want 1/0", zf, sf);
    end
`endif
  endtask

  task automatic test_sub;
    drive(1'b1, 2'd1, 64'd3, 64'd10);
    compared++;
    if (out !== 64'd7 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL sub_order: out=%h of=%0b want %h/0", out, of, 64'd7);
    end
    drive(1'b1, 2'd1, 64'd1, 64'h8000_0000_0000_0000);
    compared++;
    if (out !== 64'h7FFF_FFFF_FFFF_FFFF || of !== 1'b1) begin
      mismatched++;
      $display("FAIL sub_ovf: out=%h of=%0b want %h/1", out, of, 64'h7FFF_FFFF_FFFF_FFFF);
    end
    drive(1'b1, 2'd1, 64'd5, 64'd5);
    compared++;
    if (out !== 64'd0 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL sub_equal: out=%h of=%0b want 0/0", out, of);
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (zf !== 1'b1 || sf !== 1'b0) begin
      mismatched++;
      $display("FAIL sub_equal_flags: zf=%0b sf=%0b want 1/0", zf, sf);
    end
`endif
  endtask

  task automatic test_logic;
    drive(1'b1, 2'd2, 64'hF0F0, 64'hFF00);
    compared++;
    if (out !== 64'hF000 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL and_op: out=%h of=%0b want %h/0", out, of, 64'hF000);
    end
    drive(1'b1, 2'd3, 64'hFFFF, 64'hFFFF);
    compared++;
    if (out !== 64'd0 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL xor_self: out=%h of=%0b want 0/0", out, of);
    end
    drive(1'b1, 2'd3, 64'h8000_0000_0000_0001, 64'd1);
    compared++;
    if (out !== 64'h8000_0000_0000_0000 || of !== 1'b0) begin
      mismatched++;
      $display("FAIL xor_msb: out=%h of=%0b want %h/0", out, of, 64'h8000_0000_0000_0000);
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (zf !== 1'b0 || sf !== 1'b1) begin
      mismatched++;
      $display("FAIL xor_msb_flags: zf=%0b sf=%0b want 0/1", zf, sf);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [1:0]  funs [4];
    logic [63:0] as   [4];
    logic [63:0] bs   [4];
    logic [63:0] exps [4];
    funs = '{2'd0, 2'd1, 2'd2, 2'd3};
    as   = '{64'd2, 64'h10, 64'hFF, 64'hAAAA};
    bs   = '{64'd3, 64'h30, 64'h0F0F, 64'h5555};
    exps = '{64'd5, 64'h20, 64'h0F, 64'hFFFF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, funs[i], as[i], bs[i]);
      compared++;
      if (out_valid !== 1'b1 || out !== exps[i] || of !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_%0d: out_valid=%0b out=%h of=%0b want 1/%h/0", i, out_valid, out, of, exps[i]);
      end
    end
    drive(1'b0, 2'd0, 64'd1, 64'd1);
    compared++;
    if (out_valid !== 1'b0 || out !== 64'hFFFF || of !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_idle: out_valid=%0b out=%h of=%0b want 0/%h/0", out_valid, out, of, 64'hFFFF);
    end
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    drive(1'b0, 2'd2, 64'd0, 64'd0);
    compared++;
    if (out_valid !== 1'b0 || out !== 64'h8000_0000_0000_0000 || of !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_ovf: out_valid=%0b out=%h of=%0b want 0/%h/1", out_valid, out, of, 64'h8000_0000_0000_0000);
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (zf !== 1'b0 || sf !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_flags: zf=%0b sf=%0b want 0/1", zf, sf);
    end
`endif
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    fun        = 2'd0;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (out !== 64'd0 || of !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL initial_reset: out=%h of=%0b out_valid=%0b want 0/0/0", out, of, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/y86_alu_wrapper.md
Name: y86_alu_wrapper

Overview:
- Registered 64-bit integer ALU for the Y86-64 execute stage.
- Computes add, sub, and, xor on two operands and produces the result plus a signed-overflow flag.
- Used for both OPq arithmetic and address/stack-pointer arithmetic (e.g. B + 8, B + (-8), C + 0).
- One pipeline register on the output; the execute stage derives ZF/SF/Cnd from the registered result.

Parameters:
- WIDTH, 64, operand and result width in bits. All requirements below hold for any WIDTH >= 2; the bench uses 64.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and fun valid this cycle
- fun  input  2  operation select: 0 add, 1 sub, 2 and, 3 xor
- a  input  WIDTH  operand A (valA / valC / ±8)
- b  input  WIDTH  operand B (valB / 0)
- out_valid  output  1  out/of hold a new result
- out  output  WIDTH  registered result
- of  output  1  registered signed overflow

Behaviour:
- Reset (rst_n low, asynchronous, any time): out = 0, of = 0, out_valid = 0. Outputs stay there while rst_n is low. No in-flight operation survives reset.
- Latency is exactly 1 cycle. If in_valid = 1 at rising edge N, then out, of and out_valid = 1 are visible after edge N.
- If in_valid = 0 at an edge, out_valid goes to 0 and out/of hold their previous values.
- No backpressure; a new operation is accepted every cycle.
- fun = 0: out = a + b, modulo 2^WIDTH.
- fun = 1: out = b - a, modulo 2^WIDTH. This is Y86 subq order: rB - rA.
- fun = 2: out = a & b.
- fun = 3: out = a ^ b.
- Overflow for add: of = 1 iff a[MSB] == b[MSB] and out[MSB] != a[MSB].
- Overflow for sub: of = 1 iff a[MSB] != b[MSB] and out[MSB] != b[MSB].
- Overflow for and/xor: of = 0.
- Carry/borrow out of the MSB is discarded and never reported.
- All operands are two's-complement. -8 arrives as all-ones except the low bits 1000.
- The combinational result depends only on the current a, b, fun. There is no internal state besides the output register.

Optional Feature:
- Macro ALU_FLAGS_EN adds two outputs, zf (1 bit) and sf (1 bit), registered alongside out with the same timing.
- zf = 1 iff the new result is all-zero. sf = the new result's MSB.
- Both reset to 0 and hold their values when in_valid = 0.
- Without ALU_FLAGS_EN, the ports are absent and the module has no flag logic.

Decomposition:
- Shared package alu_pkg holds:
  - localparam encodings ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_XOR = 2'd3;
  - typedef alu_fun_t (2-bit enum).
- One natural combinational sub-module, alu_core: a, b, fun in; result and of out, with no clock.
- y86_alu_wrapper instantiates alu_core and adds the output register, valid tracking and the optional flag register.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with in_valid = 1 -> out = 0, of = 0, out_valid = 0 immediately and until release. The first in_valid after release gives out_valid = 1 one edge later.
- Add and stack math:
  - fun = 0, a = 0xFFFFFFFFFFFFFFF8 (-8), b = 0x100 -> out = 0xF8, of = 0.
  - fun = 0, a = 0x7FFFFFFFFFFFFFFF, b = 1 -> out = 0x8000000000000000, of = 1.
- Sub order and overflow:
  - fun = 1, a = 3, b = 10 -> out = 7, of = 0.
  - fun = 1, a = 1, b = 0x8000000000000000 -> out = 0x7FFFFFFFFFFFFFFF, of = 1.
  - fun = 1, a = 5, b = 5 -> out = 0, of = 0 (zf = 1 with ALU_FLAGS_EN).
- Logic ops:
  - fun = 2, a = 0xF0F0, b = 0xFF00 -> out = 0xF000, of = 0.
  - fun = 3, a = 0xFFFF, b = 0xFFFF -> out = 0, of = 0.
  - fun = 3 with MSB set in a only -> sf = 1 with ALU_FLAGS_EN.
- Throughput/hold: back-to-back in_valid for 4 cycles with distinct ops -> 4 consecutive correct results, 1-cycle latency each. Then in_valid = 0 -> out_valid = 0 and out/of unchanged.
- Wrap: fun = 0, a = 0xFFFFFFFFFFFFFFFF, b = 1 -> out = 0, of = 0 (carry discarded, zf = 1).
